data_path_mc: RTL and testbench
===============================

DATA_PATH_MC -- requirements
Module: data_path_mc

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath/register/PC width (legal 16..32).
REQ-002 The block SHALL have parameter NREG, default 16, meaning the number of general registers (legal 4..16).
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.

Interface
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low.
REQ-006 instr  in  32  fetched instruction at address pc.
REQ-007 instr_valid  in  1  instr holds a valid word for the current pc.
REQ-008 read_data  in  XLEN  data-memory read data, sampled when mem_ready=1.
REQ-009 mem_ready  in  1  data memory accepts or completes the current request.
REQ-010 dbg_addr  in  4  register index for debug read.
REQ-011 pc  out  XLEN  instruction address (registered).
REQ-012 addr_data  out  XLEN  data-memory address (registered).
REQ-013 write_data  out  XLEN  data-memory store data (registered).
REQ-014 we  out  1  store enable, valid only with mem_req.
REQ-015 mem_req  out  1  data-memory request.
REQ-016 dbg_data  out  XLEN  combinational read of register dbg_addr; reads 0 if the index is at or above NREG.

Function
REQ-017 Instruction fields SHALL be: cond[31:28], op[27:26], I[25], cmd[24:21], S[20], Rn[19:16], Rd[15:12], and imm12[11:0] or Rm[3:0].
REQ-018 Operand2 SHALL be zero-extended imm12 when I=1, else register Rm.
REQ-019 Data-processing ops (op=00) SHALL be: cmd 0000 AND, 0010 SUB (Rn-op2), 0100 ADD, 1100 ORR, 1101 MOV (op2), 1010 CMP (Rn-op2, flags only); all other cmd values are NOPs.
REQ-020 Memory ops (op=01) SHALL compute address Rn+imm12 when bit23=1, else Rn-imm12; bit20=1 selects LDR, bit20=0 selects STR.
REQ-021 Branch (op=10) SHALL set pc to pc+8+(sign-extended imm24 shifted left 2), truncated to XLEN.
REQ-022 op=11 SHALL be a NOP.
REQ-023 The condition field SHALL be evaluated as: 0000 always, 0001 EQ (Z=1), 0010 NE (Z=0), any other value always; a failed condition makes the instruction a NOP.
REQ-024 The Z flag SHALL update on CMP, or on a data-processing op with S=1, to (result==0); otherwise Z holds.
REQ-025 All arithmetic SHALL be XLEN bits modulo 2^XLEN; no carry or overflow state.
REQ-026 Reads of a register index at or above NREG SHALL return 0; writes to such an index SHALL be dropped.
REQ-027 The FSM SHALL have states FETCH, EXEC, and MEM.
REQ-028 FETCH SHALL wait while instr_valid=0; on a clock edge with instr_valid=1 it SHALL latch instr into IR and move to EXEC.
REQ-029 EXEC for data-processing or NOP SHALL write Rd (except CMP), set pc to pc+4, and return to FETCH.
REQ-030 EXEC for a taken branch SHALL load the branch target into pc and return to FETCH.
REQ-031 EXEC for LDR/STR SHALL register addr_data, set write_data to Rd, set we to 1 for STR and 0 for LDR, set mem_req to 1, and move to MEM.
REQ-032 MEM SHALL hold mem_req, we, addr_data, and write_data stable until a clock edge with mem_ready=1.
REQ-033 On that edge, LDR SHALL write read_data into Rd; both LDR and STR SHALL then clear mem_req and we, set pc to pc+4, and return to FETCH.
REQ-034 mem_req=1 with mem_ready=1 in the same cycle SHALL complete in one MEM cycle (minimum STR/LDR latency 3 cycles, data-processing 2 cycles).
REQ-035 mem_req and we SHALL be 0 in every state other than MEM; addr_data and write_data hold their last values.

Reset
REQ-036 While reset=0, asynchronously: pc=RESET_PC, state=FETCH, mem_req=0, we=0, addr_data=0, write_data=0, all registers=0, Z=0, IR=0.
REQ-037 Reset asserted during MEM SHALL drop mem_req and we in the same instant, with no register write.
REQ-038 The first fetch SHALL occur on the first rising edge after reset deasserts with instr_valid=1.

Verification
REQ-039 Reset, then MOV r3,#2 (0x03A03002) with instr_valid=1 -> r3=2, pc 0->4 after 2 edges, mem_req stays 0.
REQ-040 ADD r3,r3,#1 (0x02833001) then SUB r4,r3,#1 (0x02434001) -> r3=3, r4=2, pc=0xC.
REQ-041 STR r3,[r0,#16] (0x05803010) with mem_ready=0 for 3 cycles -> mem_req=1, we=1, addr_data=0x10, write_data=3 held 4 cycles; pc increments only after the ready edge.
REQ-042 LDR r4,[r0,#16] (0x05904010) with read_data=0xA5 and mem_ready=1 -> r4=0xA5 after 3 edges, we=0 throughout.
REQ-043 With r3=3: CMP r3,#3 (0x03530003) -> Z=1; then BEQ at pc=0x10 (0x1A000002) -> pc=0x20; the same branch with Z=0 -> pc=0x14.
REQ-044 reset=0 mid-MEM -> mem_req=0 and we=0 immediately, pc=RESET_PC; with NREG=8, MOV r12,#7 leaves dbg_data(12)=0.

Source files
------------

// File: rtl/data_path_mc.sv
// data_path_mc: multi-cycle datapath with a FETCH / EXEC / MEM controller.
// Each instruction is latched into IR in FETCH and executed in EXEC.
// Loads and stores also spend one or more cycles in MEM, holding the
// request until the data memory reports ready. The register file and the
// Z flag live here. Writes to a register index at or above NREG are
// dropped, and reads of such an index return zero.
module data_path_mc #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] read_data,
  input  logic            mem_ready,
  input  logic [3:0]      dbg_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] addr_data,
  output logic [XLEN-1:0] write_data,
  output logic            we,
  output logic            mem_req,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] PC_AHEAD  = XLEN'(8);
  localparam logic [3:0]      CMD_AND   = 4'b0000;
  localparam logic [3:0]      CMD_SUB   = 4'b0010;
  localparam logic [3:0]      CMD_ADD   = 4'b0100;
  localparam logic [3:0]      CMD_CMP   = 4'b1010;
  localparam logic [3:0]      CMD_ORR   = 4'b1100;
  localparam logic [3:0]      CMD_MOV   = 4'b1101;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_data_q, addr_data_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic            mem_req_q, mem_req_d;
  logic            we_q, we_d;
  logic            z_q, z_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // A 16-entry view of the register file. Every 4-bit index can be used
  // here, and the entries at or above NREG read as zero.
  logic [XLEN-1:0] reg_view [16];

  for (genvar g = 0; g < 16; g++) begin : g_view
    if (g < NREG) begin : g_real
      assign reg_view[g] = regs_q[g];
    end else begin : g_zero
      assign reg_view[g] = '0;
    end
  end

  // Instruction fields. They are decoded from IR, which stays stable for
  // EXEC and MEM.
  logic [3:0]      cond;
  logic [1:0]      op;
  logic            i_bit;
  logic [3:0]      cmd;
  logic            s_bit;
  logic [3:0]      rn_idx;
  logic [3:0]      rd_idx;
  logic [3:0]      rm_idx;
  logic [11:0]     imm12;
  logic            up_bit;
  logic            load_bit;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rn_val;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] op2;
  logic [31:0]     br_off;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] mem_addr;

  assign cond      = ir_q[31:28];
  assign op        = ir_q[27:26];
  assign i_bit     = ir_q[25];
  assign cmd       = ir_q[24:21];
  assign s_bit     = ir_q[20];
  assign rn_idx    = ir_q[19:16];
  assign rd_idx    = ir_q[15:12];
  assign rm_idx    = ir_q[3:0];
  assign imm12     = ir_q[11:0];
  assign up_bit    = ir_q[23];
  assign load_bit  = ir_q[20];
  assign imm_ext   = {{(XLEN-12){1'b0}}, imm12};
  assign rn_val    = reg_view[rn_idx];
  assign rd_val    = reg_view[rd_idx];
  assign op2       = i_bit ? imm_ext : reg_view[rm_idx];
  assign br_off    = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
  assign br_target = pc_q + PC_AHEAD + br_off[XLEN-1:0];
  assign mem_addr  = up_bit ? (rn_val + imm_ext) : (rn_val - imm_ext);

  // Evaluate the condition field. EQ and NE test Z, and every other
  // encoding always executes.
  logic cond_ok;
  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      4'b0001: cond_ok = z_q;
      4'b0010: cond_ok = ~z_q;
      default: cond_ok = 1'b1;
    endcase
  end

  // Data-processing ALU. Undefined cmd encodings give dp_valid=0, and
  // those instructions behave as NOPs.
  logic [XLEN-1:0] alu_res;
  logic            dp_valid;
  always_comb begin
    alu_res  = '0;
    dp_valid = 1'b1;
    case (cmd)
      CMD_AND: alu_res = rn_val & op2;
      CMD_SUB: alu_res = rn_val - op2;
      CMD_ADD: alu_res = rn_val + op2;
      CMD_ORR: alu_res = rn_val | op2;
      CMD_MOV: alu_res = op2;
      CMD_CMP: alu_res = rn_val - op2;
      default: dp_valid = 1'b0;
    endcase
  end

  // Next-state logic for the controller, the memory interface, the flag
  // and the single register-file write port.
  logic            wr_en;
  logic [3:0]      wr_idx;
  logic [XLEN-1:0] wr_val;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_data_d  = addr_data_q;
    write_data_d = write_data_q;
    mem_req_d    = mem_req_q;
    we_d         = we_q;
    z_d          = z_q;
    ir_d         = ir_q;
    regs_d       = regs_q;
    wr_en        = 1'b0;
    wr_idx       = rd_idx;
    wr_val       = '0;

    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_STEP;
        if (cond_ok) begin
          case (op)
            2'b00: begin
              if (dp_valid) begin
                if (cmd != CMD_CMP) begin
                  wr_en  = 1'b1;
                  wr_val = alu_res;
                end
                if (cmd == CMD_CMP || s_bit) begin
                  z_d = (alu_res == '0);
                end
              end
            end
            2'b01: begin
              addr_data_d  = mem_addr;
              write_data_d = rd_val;
              we_d         = ~load_bit;
              mem_req_d    = 1'b1;
              pc_d         = pc_q;
              state_d      = MEM;
            end
            2'b10: begin
              pc_d = br_target;
            end
            default: begin
            end
          endcase
        end
      end

      MEM: begin
        if (mem_ready) begin
          if (load_bit) begin
            wr_en  = 1'b1;
            wr_val = read_data;
          end
          mem_req_d = 1'b0;
          we_d      = 1'b0;
          pc_d      = pc_q + PC_STEP;
          state_d   = FETCH;
        end
      end

      default: begin
        state_d   = FETCH;
        mem_req_d = 1'b0;
        we_d      = 1'b0;
      end
    endcase

    for (int i = 0; i < NREG; i++) begin
      if (wr_en && wr_idx == 4'(i)) begin
        regs_d[i] = wr_val;
      end
    end
  end

  // State register. Reset is asynchronous, so a reset during MEM drops
  // the request immediately and no register write happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      addr_data_q  <= '0;
      write_data_q <= '0;
      mem_req_q    <= 1'b0;
      we_q         <= 1'b0;
      z_q          <= 1'b0;
      ir_q         <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_data_q  <= addr_data_d;
      write_data_q <= write_data_d;
      mem_req_q    <= mem_req_d;
      we_q         <= we_d;
      z_q          <= z_d;
      ir_q         <= ir_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign pc         = pc_q;
  assign addr_data  = addr_data_q;
  assign write_data = write_data_q;
  assign we         = we_q;
  assign mem_req    = mem_req_q;
  assign dbg_data   = reg_view[dbg_addr];

endmodule

// File: tb/tb_data_path_mc.sv
// Testbench for data_path_mc. A table of instructions with hand-computed
// results is run through the default-parameter instance. A second
// instance (NREG=8, RESET_PC=0x100) gets the same stimulus, which exposes
// dropped high-register writes and the reset PC. Hand-written sequences
// cover the FETCH wait and a reset asserted during MEM.
module tb_data_path_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] read_data;
  logic        mem_ready;
  logic [3:0]  dbg_addr;

  logic [31:0] pc, addr_data, write_data, dbg_data;
  logic        we, mem_req;
  logic [31:0] pc8, addr_data8, write_data8, dbg_data8;
  logic        we8, mem_req8;

  int check_count = 0;
  int error_count = 0;

  localparam logic [31:0] PC8_BASE = 32'h100;

  always #5 clk = ~clk;

  data_path_mc dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .read_data(read_data), .mem_ready(mem_ready), .dbg_addr(dbg_addr),
    .pc(pc), .addr_data(addr_data), .write_data(write_data), .we(we),
    .mem_req(mem_req), .dbg_data(dbg_data)
  );

  data_path_mc #(.XLEN(32), .NREG(8), .RESET_PC(32'h100)) dut8 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .read_data(read_data), .mem_ready(mem_ready), .dbg_addr(dbg_addr),
    .pc(pc8), .addr_data(addr_data8), .write_data(write_data8), .we(we8),
    .mem_req(mem_req8), .dbg_data(dbg_data8)
  );

  typedef struct {
    logic [31:0] word;
    bit          is_mem;
    int          wait_cycles;
    logic [31:0] rdata;
    logic [3:0]  reg_idx;
    logic [31:0] reg_val;
    logic [31:0] pc_after;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  // Compare one value with its expected value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Run one instruction from FETCH back to FETCH. This is called and
  // returns on a falling edge, so the outputs are sampled away from the
  // rising edge.
  task automatic applyStimulus(input vec_t v, input logic [31:0] pc_before,
                               input int idx);
    instr       = v.word;
    instr_valid = 1'b1;
    mem_ready   = 1'b0;
    read_data   = v.rdata;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 32'h0;
    checkOutput($sformatf("v%0d_exec_mem_req", idx), {31'b0, mem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    if (v.is_mem) begin
      for (int c = 0; c <= v.wait_cycles; c++) begin
        checkOutput($sformatf("v%0d_c%0d_mem_req", idx, c), {31'b0, mem_req}, 32'h1);
        checkOutput($sformatf("v%0d_c%0d_we", idx, c), {31'b0, we}, {31'b0, v.exp_we});
        checkOutput($sformatf("v%0d_c%0d_addr", idx, c), addr_data, v.exp_addr);
        checkOutput($sformatf("v%0d_c%0d_wdata", idx, c), write_data, v.exp_wdata);
        checkOutput($sformatf("v%0d_c%0d_pc_hold", idx, c), pc, pc_before);
        mem_ready = (c == v.wait_cycles);
        @(posedge clk);
        @(negedge clk);
      end
      mem_ready = 1'b0;
    end
    checkOutput($sformatf("v%0d_mem_req_done", idx), {31'b0, mem_req}, 32'h0);
    checkOutput($sformatf("v%0d_we_done", idx), {31'b0, we}, 32'h0);
    checkOutput($sformatf("v%0d_pc", idx), pc, v.pc_after);
    checkOutput($sformatf("v%0d_pc8", idx), pc8, v.pc_after + PC8_BASE);
    dbg_addr = v.reg_idx;
    #1;
    checkOutput($sformatf("v%0d_r%0d", idx, v.reg_idx), dbg_data, v.reg_val);
  endtask

  initial begin
    logic [31:0] exp_pc;

    // word, mem, wait, rdata, reg, reg value, pc after, we, addr, wdata
    vecs[0]  = '{32'h03A03002, 1'b0, 0, 32'h0,    4'd3,  32'd2,        32'h04, 1'b0, 32'h0,  32'h0}; // MOV r3,#2
    vecs[1]  = '{32'h02833001, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h08, 1'b0, 32'h0,  32'h0}; // ADD r3,r3,#1
    vecs[2]  = '{32'h02434001, 1'b0, 0, 32'h0,    4'd4,  32'd2,        32'h0C, 1'b0, 32'h0,  32'h0}; // SUB r4,r3,#1
    vecs[3]  = '{32'h03530003, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h10, 1'b0, 32'h0,  32'h0}; // CMP r3,#3
    vecs[4]  = '{32'h1A000002, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h20, 1'b0, 32'h0,  32'h0}; // BEQ taken
    vecs[5]  = '{32'h05803010, 1'b1, 3, 32'h0,    4'd3,  32'd3,        32'h24, 1'b1, 32'h10, 32'd3}; // STR r3,[r0,#16]
    vecs[6]  = '{32'h05904010, 1'b1, 0, 32'hA5,   4'd4,  32'hA5,       32'h28, 1'b0, 32'h10, 32'd2}; // LDR r4,[r0,#16]
    vecs[7]  = '{32'h03530004, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h2C, 1'b0, 32'h0,  32'h0}; // CMP r3,#4
    vecs[8]  = '{32'h1A000002, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h30, 1'b0, 32'h0,  32'h0}; // BEQ not taken
    vecs[9]  = '{32'h2A000002, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h40, 1'b0, 32'h0,  32'h0}; // BNE taken
    vecs[10] = '{32'hEAFFFFFE, 1'b0, 0, 32'h0,    4'd3,  32'd3,        32'h40, 1'b0, 32'h0,  32'h0}; // B -8
    vecs[11] = '{32'h0383500C, 1'b0, 0, 32'h0,    4'd5,  32'h0F,       32'h44, 1'b0, 32'h0,  32'h0}; // ORR r5,r3,#12
    vecs[12] = '{32'h00056004, 1'b0, 0, 32'h0,    4'd6,  32'h05,       32'h48, 1'b0, 32'h0,  32'h0}; // AND r6,r5,r4
    vecs[13] = '{32'h00537003, 1'b0, 0, 32'h0,    4'd7,  32'h0,        32'h4C, 1'b0, 32'h0,  32'h0}; // SUBS r7,r3,r3
    vecs[14] = '{32'h23A08009, 1'b0, 0, 32'h0,    4'd8,  32'h0,        32'h50, 1'b0, 32'h0,  32'h0}; // MOVNE r8,#9 skipped
    vecs[15] = '{32'h1A000002, 1'b0, 0, 32'h0,    4'd7,  32'h0,        32'h60, 1'b0, 32'h0,  32'h0}; // BEQ taken (S flag)
    vecs[16] = '{32'h02409001, 1'b0, 0, 32'h0,    4'd9,  32'hFFFFFFFF, 32'h64, 1'b0, 32'h0,  32'h0}; // SUB r9,r0,#1
    vecs[17] = '{32'h0513A001, 1'b1, 1, 32'h1234, 4'd10, 32'h1234,     32'h68, 1'b0, 32'h2,  32'h0}; // LDR r10,[r3,#-1]
    vecs[18] = '{32'h0C00B005, 1'b0, 0, 32'h0,    4'd11, 32'h0,        32'h6C, 1'b0, 32'h0,  32'h0}; // op=11 NOP
    vecs[19] = '{32'h03A0C007, 1'b0, 0, 32'h0,    4'd12, 32'd7,        32'h70, 1'b0, 32'h0,  32'h0}; // MOV r12,#7

    reset       = 1'b0;
    instr       = 32'h0;
    instr_valid = 1'b0;
    read_data   = 32'h0;
    mem_ready   = 1'b0;
    dbg_addr    = 4'd3;

    // Hold reset across two rising edges, then check the reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_pc8", pc8, PC8_BASE);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset_we", {31'b0, we}, 32'h0);
    checkOutput("reset_addr", addr_data, 32'h0);
    checkOutput("reset_wdata", write_data, 32'h0);
    checkOutput("reset_r3", dbg_data, 32'h0);
    reset = 1'b1;

    // FETCH waits while instr_valid is low.
    repeat (3) @(negedge clk);
    checkOutput("idle_pc", pc, 32'h0);
    checkOutput("idle_mem_req", {31'b0, mem_req}, 32'h0);

    exp_pc = 32'h0;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], exp_pc, i);
      exp_pc = vecs[i].pc_after;
      @(negedge clk);
    end

    // r12 exists only in the 16-register instance.
    dbg_addr = 4'd12;
    #1;
    checkOutput("r12_nreg16", dbg_data, 32'd7);
    checkOutput("r12_nreg8", dbg_data8, 32'h0);
    dbg_addr = 4'd3;
    #1;
    checkOutput("r3_nreg8", dbg_data8, 32'd3);

    // Assert reset asynchronously while a store waits in MEM.
    @(negedge clk);
    instr       = 32'h05803010;
    instr_valid = 1'b1;
    mem_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_mem_req", {31'b0, mem_req}, 32'h1);
    checkOutput("pre_reset_we", {31'b0, we}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("async_we", {31'b0, we}, 32'h0);
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_pc8", pc8, PC8_BASE);
    checkOutput("async_addr", addr_data, 32'h0);
    checkOutput("async_r3", dbg_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // The first instruction after reset runs from pc 0 again.
    applyStimulus(vecs[0], 32'h0, 100);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
